// File: rtl/full_alu_pkg.sv
// Shared constants and operation codes for the 16-bit registered ALU slice.
// The optional set-less-than behaviour for Func 7 is enabled by FULL_ALU_SLT_EN.
package full_alu_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'd0,
    ALUOP_SUB  = 2'd1,
    ALUOP_FUNC = 2'd2,
    ALUOP_OR   = 2'd3
  } aluop_e;

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_AND  = 4'd2,
    FN_OR   = 4'd3,
    FN_NOR  = 4'd4,
    FN_NAND = 4'd5,
    FN_XOR  = 4'd6,
    FN_SLT  = 4'd7
  } func_e;

endpackage

// File: rtl/full_alu_core.sv
// Combinational ALU core: operation select from aluop/func, result and signed overflow.
// Func 7 becomes set-less-than when FULL_ALU_SLT_EN is defined.
module alu_core #(
  parameter int unsigned WIDTH = full_alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       aluop,
  input  logic [3:0]       func,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  import full_alu_pkg::*;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (aluop)
      ALUOP_ADD: begin y = sum;  ovf = add_ovf; end
      ALUOP_SUB: begin y = diff; ovf = sub_ovf; end
      ALUOP_OR:  y = a | b;
      ALUOP_FUNC: begin
        case (func)
          FN_ADD:  begin y = sum;  ovf = add_ovf; end
          FN_SUB:  begin y = diff; ovf = sub_ovf; end
          FN_AND:  y = a & b;
          FN_OR:   y = a | b;
          FN_NOR:  y = ~(a | b);
          FN_NAND: y = ~(a & b);
          FN_XOR:  y = a ^ b;
`ifdef FULL_ALU_SLT_EN
          // Sign of the true difference is diff MSB corrected by overflow.
          FN_SLT:  y = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
`else
          FN_SLT:  begin y = diff; ovf = sub_ovf; end
`endif
          default: begin y = '0; ovf = 1'b0; end
        endcase
      end
      default: begin y = '0; ovf = 1'b0; end
    endcase
  end

endmodule

// File: rtl/full_alu.sv
// 16-bit registered ALU slice: enable-gated operand registers, combinational core,
// enable-gated result/overflow register and flags from the result register (FULL_ALU_SLT_EN optional).
module full_alu #(
  parameter int unsigned WIDTH = full_alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             A_write,
  input  logic             B_write,
  input  logic             ALUout_write,
  input  logic [1:0]       ALUop,
  input  logic [3:0]       Func,
  output logic [WIDTH-1:0] Result,
  output logic             isNegative,
  output logic             overflow,
  output logic             isZero
);
  import full_alu_pkg::*;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] core_y;
  logic             core_ovf;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (a_q),
    .b     (b_q),
    .aluop (ALUop),
    .func  (Func),
    .y     (core_y),
    .ovf   (core_ovf)
  );

  always_comb begin
    a_d      = A_write      ? A        : a_q;
    b_d      = B_write      ? B        : b_q;
    result_d = ALUout_write ? core_y   : result_q;
    ovf_d    = ALUout_write ? core_ovf : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Result     = result_q;
  assign overflow   = ovf_q;
  assign isNegative = result_q[WIDTH-1];
  assign isZero     = (result_q == '0);

endmodule

// File: tb/tb_full_alu.sv
// Directed bench for full_alu: signed-integer reference model checked every cycle,
// plus literal expectations for each listed case.
module tb_full_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        A_write = 1'b0, B_write = 1'b0, ALUout_write = 1'b0;
  logic [1:0]  ALUop = '0;
  logic [3:0]  Func = '0;
  logic [15:0] Result;
  logic        isNegative, overflow, isZero;

  int vectors = 0;
  int miscompares = 0;
  logic armed = 1'b0;

  full_alu #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (A),
    .B            (B),
    .A_write      (A_write),
    .B_write      (B_write),
    .ALUout_write (ALUout_write),
    .ALUop        (ALUop),
    .Func         (Func),
    .Result       (Result),
    .isNegative   (isNegative),
    .overflow     (overflow),
    .isZero       (isZero)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, y} from signed integer arithmetic.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op, input logic [3:0] fn);
    int sa, sb, r, kind;
    logic [15:0] y;
    logic        v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0: kind = 0;
      2'd1: kind = 1;
      2'd3: kind = 3;
      default: kind = (fn < 4'd8) ? int'(fn) : 8;
    endcase
    y = '0;
    v = 1'b0;
    case (kind)
      0: begin r = sa + sb; y = r[15:0]; v = (r > 32767) || (r < -32768); end
      1: begin r = sa - sb; y = r[15:0]; v = (r > 32767) || (r < -32768); end
      2: y = a & b;
      3: y = a | b;
      4: y = ~(a | b);
      5: y = ~(a & b);
      6: y = a ^ b;
      7: begin
`ifdef FULL_ALU_SLT_EN
        y = (sa < sb) ? 16'h0001 : 16'h0000;
`else
        r = sa - sb; y = r[15:0]; v = (r > 32767) || (r < -32768);
`endif
      end
      default: begin y = '0; v = 1'b0; end
    endcase
    return {v, y};
  endfunction

  logic [15:0] m_a, m_b, m_r;
  logic        m_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_r <= '0; m_o <= 1'b0;
    end else begin
      if (ALUout_write) {m_o, m_r} <= model(m_a, m_b, ALUop, Func);
      if (A_write) m_a <= A;
      if (B_write) m_b <= B;
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("model_result",   Result,              m_r);
      check("model_overflow", {15'd0, overflow},   {15'd0, m_o});
      check("model_zero",     {15'd0, isZero},     {15'd0, (m_r == 16'h0000)});
      check("model_negative", {15'd0, isNegative}, {15'd0, m_r[15]});
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic [3:0] fn);
    @(negedge clk);
    A = a; B = b; ALUop = op; Func = fn;
    A_write = 1'b1; B_write = 1'b1; ALUout_write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_result",   Result,              16'h0000);
    check("reset_overflow", {15'd0, overflow},   16'h0000);
    check("reset_zero",     {15'd0, isZero},     16'h0001);
    check("reset_negative", {15'd0, isNegative}, 16'h0000);
    armed = 1'b1;
    rst_n = 1'b1;

    run_op(16'd2, 16'd5, 2'd0, 4'd0);
    check("add_2_5", Result, 16'd7);
    run_op(16'h4000, 16'h4000, 2'd0, 4'd0);
    check("add_ovf_res", Result, 16'h8000);
    check("add_ovf_flag", {15'd0, overflow}, 16'h0001);
    run_op(16'd10, 16'd2, 2'd1, 4'd0);
    check("sub_10_2", Result, 16'd8);
    run_op(16'd4, 16'd4, 2'd1, 4'd0);
    check("sub_zero", {15'd0, isZero}, 16'h0001);
    run_op(16'd0, 16'd8, 2'd1, 4'd0);
    check("sub_neg_res", Result, 16'hFFF8);
    check("sub_neg_flag", {15'd0, isNegative}, 16'h0001);
    run_op(16'hAE54, 16'h574F, 2'd2, 4'd2);
    check("fn_and", Result, 16'h0644);
    run_op(16'h54FA, 16'h7008, 2'd2, 4'd4);
    check("fn_nor", Result, 16'h8B05);
    run_op(16'h5555, 16'hA3A8, 2'd2, 4'd5);
    check("fn_nand", Result, 16'hFEFF);
    run_op(16'h5500, 16'h957F, 2'd2, 4'd6);
    check("fn_xor", Result, 16'hC07F);
    check("fn_xor_ovf", {15'd0, overflow}, 16'h0000);
    run_op(16'h0F00, 16'h00F0, 2'd3, 4'd0);
    check("op_or", Result, 16'h0FF0);
    run_op(16'h1234, 16'h5678, 2'd2, 4'd11);
    check("fn_undef", Result, 16'h0000);
    run_op(16'd8, 16'd1, 2'd2, 4'd7);
`ifdef FULL_ALU_SLT_EN
    check("fn7_8_1", Result, 16'h0000);
`else
    check("fn7_8_1", Result, 16'd7);
`endif
    run_op(16'h4000, 16'hC000, 2'd2, 4'd7);
`ifdef FULL_ALU_SLT_EN
    check("fn7_pos_neg", Result, 16'h0000);
    check("fn7_pos_neg_ovf", {15'd0, overflow}, 16'h0000);
`else
    check("fn7_pos_neg", Result, 16'h8000);
    check("fn7_pos_neg_ovf", {15'd0, overflow}, 16'h0001);
`endif
    run_op(16'h8000, 16'h7FFF, 2'd2, 4'd7);
    check("fn7_min_max", Result, 16'h0001);
    check("fn7_min_max_neg", {15'd0, isNegative}, 16'h0000);
`ifdef FULL_ALU_SLT_EN
    check("fn7_min_max_ovf", {15'd0, overflow}, 16'h0000);
`else
    check("fn7_min_max_ovf", {15'd0, overflow}, 16'h0001);
`endif

    run_op(16'd3, 16'd4, 2'd0, 4'd0);
    check("en_load", Result, 16'd7);
    @(negedge clk);
    ALUout_write = 1'b0; A = 16'd9;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("en_hold_result", Result, 16'd7);
    @(negedge clk);
    A_write = 1'b0; ALUout_write = 1'b1; A = 16'd1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("en_hold_a", Result, 16'd13);

    run_op(16'h0100, 16'h0001, 2'd0, 4'd0);
    check("pre_reset", Result, 16'h0101);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_result", Result, 16'h0000);
    check("async_reset_zero", {15'd0, isZero}, 16'h0001);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("after_reset", Result, 16'h0101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
